piano_key_tracker: RTL

PIANO_KEY_TRACKER -- requirements
Module: piano_key_tracker

---
 rtl/piano_key_tracker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/piano_key_tracker.sv
// rtl/piano_key_tracker.sv - PS/2 set-2 keyboard to MIDI note event tracker with event FIFO
module piano_key_tracker #(
  parameter int NUM_KEYS   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int OCT_MIN    = 1,
  parameter int OCT_MAX    = 7,
  parameter int OCT_RST    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [7:0]          code_byte,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                evt_on,
  output logic [6:0]          evt_note,
  output logic [NUM_KEYS-1:0] held,
  output logic                mono_active,
  output logic [6:0]          mono_note,
  output logic [3:0]          octave,
  output logic                overflow
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] OCT_MIN_L = 4'(OCT_MIN);
  localparam logic [3:0] OCT_MAX_L = 4'(OCT_MAX);
  localparam logic [3:0] OCT_RST_L = 4'(OCT_RST);

  localparam logic [7:0] KEYMAP [24] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
  };

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  function automatic logic [6:0] note_of(input logic [3:0] oct, input logic [IDX_W-1:0] idx);
    return 7'd12 * (7'(oct) + 7'd1) + 7'(idx);
  endfunction

  state_t               state_q, state_d;
  logic [NUM_KEYS-1:0]  held_q, held_d;
  logic [3:0]           oct_q, oct_d;
  logic                 mono_active_q, mono_active_d;
  logic [6:0]           mono_note_q, mono_note_d;
  logic                 overflow_q, overflow_d;
  logic [3:0]           key_oct_q [NUM_KEYS];
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W:0]       wptr_q, rptr_q;

  logic                 is_make, is_break;
  logic                 key_hit, key_held, key_oct_we;
  logic [IDX_W-1:0]     key_idx;
  logic [6:0]           make_note, brk_note;
  logic                 push_req, push, pop, full, empty;
  logic [7:0]           push_data, head;

  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code_byte == 8'hF0)      state_d = S_BREAK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else                         is_make = 1'b1;
        end
        S_BREAK: begin
          is_break = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT:       state_d = (code_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        S_EXT_BREAK: state_d = (code_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    key_hit = 1'b0;
    key_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (code_byte == KEYMAP[i]) begin
        key_hit = 1'b1;
        key_idx = IDX_W'(i);
      end
    end
  end

  assign key_held  = held_q[key_idx];
  assign make_note = note_of(oct_q, key_idx);
  // Release uses the octave latched at press time so on/off notes always pair up
  assign brk_note  = note_of(key_oct_q[key_idx], key_idx);

  always_comb begin
    held_d        = held_q;
    oct_d         = oct_q;
    mono_active_d = mono_active_q;
    mono_note_d   = mono_note_q;
    key_oct_we    = 1'b0;
    push_req      = 1'b0;
    push_data     = '0;
    if (is_make) begin
      if (code_byte == 8'h6B) begin
        if (oct_q < OCT_MAX_L) oct_d = oct_q + 4'd1;
      end else if (code_byte == 8'h74) begin
        if (oct_q > OCT_MIN_L) oct_d = oct_q - 4'd1;
      end else if (key_hit && !key_held) begin
        held_d[key_idx] = 1'b1;
        key_oct_we      = 1'b1;
        push_req        = 1'b1;
        push_data       = {1'b1, make_note};
        mono_active_d   = 1'b1;
        mono_note_d     = make_note;
      end
    end else if (is_break && key_hit && key_held) begin
      held_d[key_idx] = 1'b0;
      push_req        = 1'b1;
      push_data       = {1'b0, brk_note};
      if (mono_note_q == brk_note) mono_active_d = 1'b0;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop   = evt_ready && !empty;
  // A pop frees the head slot this same edge, so a push at full is still accepted
  assign push  = push_req && (!full || pop);
  assign overflow_d = overflow_q || (push_req && full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      held_q        <= '0;
      oct_q         <= OCT_RST_L;
      mono_active_q <= 1'b0;
      mono_note_q   <= '0;
      overflow_q    <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      for (int i = 0; i < NUM_KEYS; i++) key_oct_q[i] <= OCT_RST_L;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      oct_q         <= oct_d;
      mono_active_q <= mono_active_d;
      mono_note_q   <= mono_note_d;
      overflow_q    <= overflow_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (key_oct_we) key_oct_q[key_idx] <= oct_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q[PTR_W-1:0]] <= push_data;
  end

  assign head        = mem_q[rptr_q[PTR_W-1:0]];
  assign evt_valid   = !empty;
  assign evt_on      = !empty && head[7];
  assign evt_note    = empty ? 7'd0 : head[6:0];
  assign held        = held_q;
  assign mono_active = mono_active_q;
  assign mono_note   = mono_note_q;
  assign octave      = oct_q;
  assign overflow    = overflow_q;

endmodule
